// File: rtl/alu_muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package alu_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_W = $clog2(DATA_WIDTH_DEF);

  function automatic logic is_signed_a(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/alu_muldiv_datapath.sv
// Magnitude shift-add multiplier / restoring divider sharing one 2W work register,
// with sign fixup on the way out. Advanced one bit per cycle by the step strobe.
module muldiv_datapath
  import alu_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  load,
  input  logic                  step,
  input  muldiv_op_e            op,
  input  logic [DATA_WIDTH-1:0] srcA,
  input  logic [DATA_WIDTH-1:0] srcB,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W = DATA_WIDTH;

  logic [2*W-1:0] work;
  logic [W-1:0]   divisor;
  muldiv_op_e     opReg;
  logic           negMain;
  logic           negRem;

  logic           negA, negB;
  logic [W-1:0]   absA, absB;
  logic [W:0]     mulSum, divTop, divDiff;
  logic [2*W-1:0] workNext;
  logic [2*W-1:0] product;
  logic [W-1:0]   quotient, remainder;

  always_comb begin
    negA = is_signed_a(op) && srcA[W-1];
    negB = is_signed_b(op) && srcB[W-1];
    absA = negA ? -srcA : srcA;
    absB = negB ? -srcB : srcB;
  end

  // Multiply: upper half accumulates, multiplier drains out of the lower half.
  // Divide: shift the partial remainder left and subtract the divisor if it fits.
  always_comb begin
    mulSum  = {1'b0, work[2*W-1:W]} + (work[0] ? {1'b0, divisor} : '0);
    divTop  = work[2*W-1:W-1];
    divDiff = divTop - {1'b0, divisor};
    if (opReg[2]) begin
      workNext = divDiff[W] ? {divTop[W-1:0], work[W-2:0], 1'b0}
                            : {divDiff[W-1:0], work[W-2:0], 1'b1};
    end else begin
      workNext = {mulSum, work[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      work    <= {{W{1'b0}}, absA};
      divisor <= absB;
      opReg   <= op;
      negMain <= negA ^ negB;
      negRem  <= negA;
    end else if (step) begin
      work <= workNext;
    end
  end

  always_comb begin
    product   = negMain ? -work : work;
    quotient  = negMain ? -work[W-1:0] : work[W-1:0];
    remainder = negRem ? -work[2*W-1:W] : work[2*W-1:W];
    case (opReg)
      OP_MUL:                       result = product[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = product[2*W-1:W];
      OP_DIV, OP_DIVU:              result = quotient;
      default:                      result = remainder;
    endcase
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: FSM, bit counter, handshakes and fast paths.
// Define ALU_MULDIV_FAST_MUL_EN to compute MUL* ops in one cycle with a single multiplier.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    Result
);

  localparam int W = DATA_WIDTH;
  // Counter is never narrower than the package default width.
  localparam int CntW = (W > (1 << CNT_W)) ? $clog2(W) : CNT_W;
  localparam logic [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};

  muldiv_state_e state, nextState;
  logic [CntW-1:0] count;
  muldiv_op_e      op;
  logic            accept;
  logic            divZero, overflow;
  logic            fastHit, fastHitReg;
  logic [W-1:0]    fastVal, fastValReg;
  logic [W-1:0]    dpResult;

  assign op       = muldiv_op_e'(Operation[2:0]);
  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready && !flush;

`ifdef ALU_MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fastProd;
  assign fastProd = {{W{is_signed_a(op) & SrcA[W-1]}}, SrcA} *
                    {{W{is_signed_b(op) & SrcB[W-1]}}, SrcB};
`endif

  // Ops whose answer is known in the accept cycle skip the iteration entirely.
  always_comb begin
    divZero  = op[2] && (SrcB == '0);
    overflow = (op == OP_DIV || op == OP_REM) && (SrcA == MinVal) && (SrcB == '1);
    fastHit  = 1'b0;
    fastVal  = '0;
    if (divZero) begin
      fastHit = 1'b1;
      fastVal = op[1] ? SrcA : '1;
    end else if (overflow) begin
      fastHit = 1'b1;
      fastVal = op[1] ? '0 : MinVal;
    end
`ifdef ALU_MULDIV_FAST_MUL_EN
    else if (!op[2]) begin
      fastHit = 1'b1;
      fastVal = (op == OP_MUL) ? fastProd[W-1:0] : fastProd[2*W-1:W];
    end
`endif
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = fastHit ? DONE : BUSY;
      BUSY:    if (count == CntW'(W - 1)) nextState = DONE;
      DONE:    if (out_valid && out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (flush) nextState = IDLE;
  end

  // Result is captured on the first DONE cycle, then held until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      out_valid  <= 1'b0;
      Result     <= '0;
      fastHitReg <= 1'b0;
      fastValReg <= '0;
    end else begin
      state <= nextState;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (state == DONE && !out_valid) begin
        out_valid <= 1'b1;
        Result    <= fastHitReg ? fastValReg : dpResult;
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        count      <= '0;
        fastHitReg <= fastHit;
        fastValReg <= fastVal;
      end else if (state == BUSY) begin
        count <= count + CntW'(1);
      end
    end
  end

  muldiv_datapath #(
    .DATA_WIDTH(W)
  ) u_datapath (
    .clk   (clk),
    .load  (accept),
    .step  (state == BUSY),
    .op    (op),
    .srcA  (SrcA),
    .srcB  (SrcB),
    .result(dpResult)
  );

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vector table, randomized ops against
// an arithmetic reference model, and handshake/flush/reset sequences.
module tb_alu_muldiv;

  localparam int W = 32;
`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   Operation = 3'd0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] Result;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  alu_muldiv #(
    .DATA_WIDTH(W),
    .OPCODE_LENGTH(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Operation(Operation),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result   (Result)
  );

  function automatic logic [W-1:0] refResult(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = (op inside {3'd1, 3'd2, 3'd4, 3'd6}) ? longint'($signed(a)) : longint'(a);
    sb = (op inside {3'd1, 3'd4, 3'd6}) ? longint'($signed(b)) : longint'(b);
    p  = sa * sb;
    if (op == 3'd0) return p[31:0];
    if (op inside {3'd1, 3'd2, 3'd3}) return p[63:32];
    if (b == '0) return (op inside {3'd4, 3'd5}) ? 32'hFFFF_FFFF : a;
    if (op inside {3'd4, 3'd6} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (op == 3'd4) ? 32'h8000_0000 : 32'd0;
    if (op inside {3'd4, 3'd5}) return W'(sa / sb);
    return W'(sa % sb);
  endfunction

  function automatic int refLatency(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    if (!op[2]) return MulLat;
    if (b == '0) return 1;
    if (op inside {3'd4, 3'd6} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return W + 1;
  endfunction

  task automatic addVec(input string n, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] e, input int lat);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.exp = e; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL issue timeout: in_ready=%b, expected 1", in_ready);
    end
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      tests++;
      fails++;
      $display("[TB] FAIL result timeout: out_valid=%b after %0d cycles, expected 1", out_valid, lat);
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input int expLat);
    int lat;
    applyStimulus(op, a, b);
    waitResult(lat);
    checkOutput(name, Result, exp);
    checkOutput($sformatf("%s latency", name), 32'(lat), 32'(expLat));
    consume();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;

    addVec("MUL 7*-3",         3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat);
    addVec("MULHU -1*-1",      3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat);
    addVec("MULH -1*-1",       3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, MulLat);
    addVec("MULHSU -1*2",      3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MulLat);
    addVec("DIV -7/2",         3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, W + 1);
    addVec("REM -7/2",         3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, W + 1);
    addVec("DIVU 100/7",       3'd5, 32'd100,        32'd7,         32'd14,        W + 1);
    addVec("REMU 100/7",       3'd7, 32'd100,        32'd7,         32'd2,         W + 1);
    addVec("DIVU 5/0",         3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    addVec("REM 13/0",         3'd6, 32'd13,         32'd0,         32'd13,        1);
    addVec("DIV MIN/-1",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    addVec("REM MIN/-1",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
    addVec("DIV 7/-2",         3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, W + 1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset Result", Result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++)
      runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 50));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      runOp($sformatf("rand op%0d %h,%h", rop, ra, rb), rop, ra, rb,
            refResult(rop, ra, rb), refLatency(rop, ra, rb));
    end

    // Result held in DONE while the consumer stalls, then back-to-back issue.
    applyStimulus(3'd0, 32'd3, 32'd5);
    waitResult(lat);
    checkOutput("hold first result", Result, 32'd15);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold Result", Result, 32'd15);
      checkOutput("hold out_valid", 32'(out_valid), 32'd1);
      checkOutput("hold in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    Operation = 3'd5;
    SrcA      = 32'd100;
    SrcB      = 32'd7;
    @(posedge clk);
    #1;
    checkOutput("release in_ready", 32'(in_ready), 32'd1);
    checkOutput("release out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    checkOutput("back-to-back accept", 32'(in_ready), 32'd0);
    waitResult(lat);
    checkOutput("back-to-back DIVU", Result, 32'd14);
    checkOutput("back-to-back latency", 32'(lat), 32'(W + 1));
    consume();

    // Flush a divide at count 10.
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checkOutput("flush busy in_ready", 32'(in_ready), 32'd1);
    checkOutput("flush busy out_valid", 32'(out_valid), 32'd0);

    // Flush in IDLE must block an accept in the same cycle.
    @(negedge clk);
    flush     = 1'b1;
    in_valid  = 1'b1;
    Operation = 3'd0;
    SrcA      = 32'd3;
    SrcB      = 32'd3;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush blocks accept", 32'(in_ready), 32'd1);
    runOp("after flush DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, W + 1);

    // Flush in DONE drops the unconsumed result.
    applyStimulus(3'd0, 32'd6, 32'd7);
    waitResult(lat);
    checkOutput("pre-flush MUL 6*7", Result, 32'd42);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checkOutput("flush done out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush done in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of an iterative op.
    applyStimulus(3'd4, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid-reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid-reset Result", Result, 32'd0);
    checkOutput("mid-reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    runOp("after reset REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, W + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
